// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-stage wrapper in front of a 32-bit combinational ALU.
// Decodes aluop/funct into the 3-bit ALU control code, registers operands and
// control into S0 (which drives the ALU directly), then captures the ALU result
// into S1 (which drives the out_* ports). Two-stage, fully back-pressured,
// one op per cycle.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input handshake
//   in_aluop, in_funct         main-decoder op class, R-type funct
//   in_a, in_b                 operands
//   alu_a, alu_b, alu_control  S0 outputs driven into the ALU
//   alu_result, alu_zero       combinational return from the ALU
//   out_valid/out_ready        output handshake
//   out_result, out_zero       registered ALU result and zero flag
//   out_illegal                op had an undecodable aluop/funct
//   illegal_cnt                saturating count of illegal ops delivered
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       dec_ctl;
  logic             dec_illegal;

  logic             s0_valid;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  logic [2:0]       s0_ctl;
  logic             s0_illegal;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_result;
  logic             s1_zero;
  logic             s1_illegal;

  logic             s1_adv;
  logic             s0_adv;
  logic             in_fire;
  logic             out_fire;

  // aluop/funct decode; illegal ops fall back to add so the ALU sees a defined code
  always_comb begin
    dec_ctl     = CTL_ADD;
    dec_illegal = 1'b0;
    unique case (in_aluop)
      2'b00: dec_ctl = CTL_ADD;
      2'b01: dec_ctl = CTL_SUB;
      2'b10: begin
        case (in_funct)
          6'b100000: dec_ctl = CTL_ADD;
          6'b100010: dec_ctl = CTL_SUB;
          6'b100100: dec_ctl = CTL_AND;
          6'b100101: dec_ctl = CTL_OR;
          6'b101010: dec_ctl = CTL_SLT;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Flow control; in_ready is independent of in_valid
  assign s1_adv   = !s1_valid || out_ready;
  assign s0_adv   = s0_valid && s1_adv;
  assign in_ready = !s0_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s1_valid && out_ready;

  // S0: operand/control register feeding the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid   <= 1'b0;
      s0_a       <= '0;
      s0_b       <= '0;
      s0_ctl     <= CTL_ADD;
      s0_illegal <= 1'b0;
    end else begin
      if (in_fire) begin
        s0_valid   <= 1'b1;
        s0_a       <= in_a;
        s0_b       <= in_b;
        s0_ctl     <= dec_ctl;
        s0_illegal <= dec_illegal;
      end else if (s0_adv) begin
        s0_valid <= 1'b0;
      end
    end
  end

  // S1: result register; illegal ops deliver a zeroed result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_result  <= '0;
      s1_zero    <= 1'b0;
      s1_illegal <= 1'b0;
    end else begin
      if (s0_adv) begin
        s1_valid   <= 1'b1;
        s1_result  <= s0_illegal ? '0 : alu_result;
        s1_zero    <= s0_illegal ? 1'b0 : alu_zero;
        s1_illegal <= s0_illegal;
      end else if (out_ready) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Saturating count of illegal ops handed to the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (out_fire && s1_illegal && (illegal_cnt != CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign alu_a       = s0_a;
  assign alu_b       = s0_b;
  assign alu_control = s0_ctl;

  assign out_valid   = s1_valid;
  assign out_result  = s1_result;
  assign out_zero    = s1_zero;
  assign out_illegal = s1_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: behavioural ALU closes the loop, a scoreboard
// queue holds expected {illegal, zero, result} per accepted op, and a monitor
// compares them as results are delivered. A second instance with CNT_W = 2
// shares the stimulus to exercise counter saturation.
module tb_alu_issue_stage;

  localparam int unsigned WIDTH = 32;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [1:0]        in_aluop;
  logic [5:0]        in_funct;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              out_ready;

  logic              in_ready;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
  logic [2:0]        alu_control;
  logic              alu_zero;
  logic              out_valid, out_zero, out_illegal;
  logic [WIDTH-1:0]  out_result;
  logic [15:0]       illegal_cnt;

  logic              in_ready2;
  logic [WIDTH-1:0]  alu_a2, alu_b2, alu_result2;
  logic [2:0]        alu_control2;
  logic              alu_zero2;
  logic              out_valid2, out_zero2, out_illegal2;
  logic [WIDTH-1:0]  out_result2;
  logic [1:0]        illegal_cnt2;

  int total = 0;
  int bad   = 0;
  logic [WIDTH+1:0] exp_q[$];

  function automatic logic [WIDTH:0] alu_f(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [2:0] ctl);
    logic [WIDTH-1:0] r;
    case (ctl)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
      default: r = '0;
    endcase
    return {(r == '0), r};
  endfunction

  assign {alu_zero, alu_result}   = alu_f(alu_a, alu_b, alu_control);
  assign {alu_zero2, alu_result2} = alu_f(alu_a2, alu_b2, alu_control2);

  alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_control(alu_control2),
    .alu_result(alu_result2), .alu_zero(alu_zero2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
    .out_zero(out_zero2), .out_illegal(out_illegal2), .illegal_cnt(illegal_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every output transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got result 0x%0h with nothing expected at %0t",
                 out_result, $time);
      end else begin
        logic [WIDTH+1:0] e;
        e = exp_q.pop_front();
        chk("out_result",  64'(out_result),  64'(e[WIDTH-1:0]));
        chk("out_zero",    64'(out_zero),    64'(e[WIDTH]));
        chk("out_illegal", 64'(out_illegal), 64'(e[WIDTH+1]));
      end
    end
  end

  // Present one op and hold it until accepted (bounded)
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic ill, input logic z, input logic [WIDTH-1:0] r);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    in_aluop = op; in_funct = fn; in_a = a; in_b = b; in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) exp_q.push_back({ill, z, r});
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_aluop = '0; in_funct = '0; in_a = '0; in_b = '0;
    #12;
    chk("rst_out_valid",   64'(out_valid),   64'd0);
    chk("rst_in_ready",    64'(in_ready),    64'd1);
    chk("rst_alu_control", 64'(alu_control), 64'b010);
    chk("rst_alu_a",       64'(alu_a),       64'd0);
    chk("rst_out_result",  64'(out_result),  64'd0);
    chk("rst_cnt",         64'(illegal_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add with latency probe
    in_aluop = 2'b00; in_funct = 6'h00; in_a = 32'h0000_00FF; in_b = 32'h1; in_valid = 1'b1;
    @(negedge clk);
    chk("add_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_0100});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_s0_ctl",       64'(alu_control), 64'b010);
    chk("add_s0_a",         64'(alu_a),       64'h0000_00FF);
    chk("add_early_valid",  64'(out_valid),   64'd0);
    @(negedge clk);
    chk("add_out_valid",    64'(out_valid),   64'd1);
    drain();

    // R-type sweep, back to back
    send(2'b10, 6'b100010, 32'h1,         32'h1,         1'b0, 1'b1, 32'h0);
    send(2'b10, 6'b100100, 32'h12345678,  32'h87654321,  1'b0, 1'b0, 32'h02244220);
    send(2'b10, 6'b100101, 32'h12345678,  32'h87654321,  1'b0, 1'b0, 32'h97755779);
    send(2'b10, 6'b101010, 32'hFFFFFFFF,  32'h0,         1'b0, 1'b0, 32'h1);
    send(2'b10, 6'b101010, 32'h0,         32'hFFFFFFFF,  1'b0, 1'b1, 32'h0);
    send(2'b10, 6'b100000, 32'h7,         32'h9,         1'b0, 1'b0, 32'h10);
    drain();

    // Back-pressure: two held, third refused until out_ready returns
    out_ready = 1'b0;
    send(2'b00, 6'h00, 32'd5,  32'd7, 1'b0, 1'b0, 32'd12);
    send(2'b01, 6'h00, 32'd10, 32'd3, 1'b0, 1'b0, 32'd7);
    in_aluop = 2'b10; in_funct = 6'b100101; in_a = 32'hF0; in_b = 32'h0F; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready",   64'(in_ready),   64'd0);
      chk("bp_out_valid",  64'(out_valid),  64'd1);
      chk("bp_out_result", 64'(out_result), 64'd12);
      chk("bp_alu_a",      64'(alu_a),      64'd10);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    exp_q.push_back({1'b0, 1'b0, 32'hFF});
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Illegal ops
    send(2'b10, 6'b000000, 32'd3, 32'd4, 1'b1, 1'b0, 32'd0);
    send(2'b11, 6'b100000, 32'd5, 32'd6, 1'b1, 1'b0, 32'd0);
    drain();
    chk("cnt_two",  64'(illegal_cnt),  64'd2);
    chk("cnt2_two", 64'(illegal_cnt2), 64'd2);
    send(2'b11, 6'h00,     32'd1, 32'd1, 1'b1, 1'b0, 32'd0);
    send(2'b00, 6'h00,     32'd1, 32'd1, 1'b0, 1'b0, 32'd2);
    send(2'b10, 6'b111111, 32'd8, 32'd8, 1'b1, 1'b0, 32'd0);
    send(2'b10, 6'b100011, 32'd9, 32'd2, 1'b1, 1'b0, 32'd0);
    drain();
    chk("cnt_five",      64'(illegal_cnt),  64'd5);
    chk("cnt2_saturate", 64'(illegal_cnt2), 64'd3);

    // Reset mid-flight with both stages full
    out_ready = 1'b0;
    send(2'b00, 6'h00, 32'd20, 32'd1, 1'b0, 1'b0, 32'd21);
    send(2'b00, 6'h00, 32'd30, 32'd1, 1'b0, 1'b0, 32'd31);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid),   64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),    64'd1);
    chk("mid_rst_cnt",       64'(illegal_cnt), 64'd0);
    chk("mid_rst_ctl",       64'(alu_control), 64'b010);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(2'b00, 6'h00, 32'd2, 32'd2, 1'b0, 1'b0, 32'd4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
